dcache_direct_wb: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage (DCACHE_* port)
//  and slow main memory. Read/write hits complete in zero stall cycles; misses stall the pipeline
//  via proc_stall while an FSM writes back a dirty victim and refills a 4-word (128-bit) line.

---
 rtl/dcache_direct_wb.sv | 214 +++++++++++++++++++++
 tb/tb_dcache_direct_wb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct_wb.sv
// dcache_direct_wb: direct-mapped, write-back, write-allocate data cache.
//   Hits (read or write) complete with no stall. A miss stalls the pipeline while
//   an FSM writes back a dirty victim line and then refills a 4-word line.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   proc_read     load request (held until proc_stall low)
//   proc_write    store request (held until proc_stall low); wins over proc_read
//   proc_addr     word address {tag, index, offset[1:0]}
//   proc_wdata    store data
//   proc_stall    request not yet serviced (combinational)
//   proc_rdata    load data of the hit word (combinational), 0 when not reading
//   mem_read      line refill request (registered)
//   mem_write     line write-back request (registered)
//   mem_addr      line address (word address >> 2)
//   mem_wdata     victim line, word0 in [31:0]
//   mem_rdata     refill line, word0 in [31:0]
//   mem_ready     one-cycle transfer-complete pulse
//
// Build option
//   DCACHE_STATS_EN  adds hit_cnt, miss_cnt, wb_cnt counter outputs.

module dcache_direct_wb #(
  parameter int unsigned INDEX_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt,
  output logic [31:0]  wb_cnt
`endif
);

  localparam int unsigned LINE_ADDR_W = 28;
  localparam int unsigned TAG_W       = LINE_ADDR_W - INDEX_W;
  localparam int unsigned LINES       = 1 << INDEX_W;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WORDS       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WBACK = 2'd1,
    ALLOC = 2'd2
  } state_t;

  // Line storage; data word0 sits in the low 32 bits of each packed line.
  logic [LINES-1:0]                valid_q;
  logic [LINES-1:0]                dirty_q;
  logic [TAG_W-1:0]                tag_q  [LINES];
  logic [WORDS-1:0][WORD_W-1:0]    data_q [LINES];

  state_t                 state_q, state_d;
  logic [LINE_ADDR_W-1:0] miss_line_q, miss_line_d;
  logic                   mem_read_d, mem_write_d;
  logic [LINE_ADDR_W-1:0] mem_addr_d;
  logic [127:0]           mem_wdata_d;
  logic                   refill, wr_hit;

  // Request address fields.
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_off;
  logic               req, hit;

  // Miss line captured at miss time so the refill finishes even if the request drops.
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_idx;

  assign req_tag  = proc_addr[29 -: TAG_W];
  assign req_idx  = proc_addr[INDEX_W+1:2];
  assign req_off  = proc_addr[1:0];
  assign req      = proc_read | proc_write;
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss_tag = miss_line_q[LINE_ADDR_W-1 -: TAG_W];
  assign miss_idx = miss_line_q[INDEX_W-1:0];

  assign proc_stall = (state_q != IDLE) || (req && !hit);
  assign proc_rdata = (proc_read && !proc_write && hit) ? data_q[req_idx][req_off] : '0;

  // State and memory-interface registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      mem_read    <= mem_read_d;
      mem_write   <= mem_write_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

  // Next state plus next values of the registered memory request.
  always_comb begin
    state_d     = state_q;
    miss_line_d = miss_line_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    refill      = 1'b0;
    wr_hit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            wr_hit = proc_write;
          end else begin
            miss_line_d = proc_addr[29:2];
            if (dirty_q[req_idx]) begin
              state_d     = WBACK;
              mem_write_d = 1'b1;
              mem_addr_d  = {tag_q[req_idx], req_idx};
              mem_wdata_d = data_q[req_idx];
            end else begin
              state_d    = ALLOC;
              mem_read_d = 1'b1;
              mem_addr_d = proc_addr[29:2];
            end
          end
        end
      end
      WBACK: begin
        mem_write_d = 1'b1;
        if (mem_ready) begin
          state_d     = ALLOC;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = miss_line_q;
        end
      end
      ALLOC: begin
        mem_read_d = 1'b1;
        if (mem_ready) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
          refill     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid/dirty bits are reset; tag/data arrays are not.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill) begin
      valid_q[miss_idx] <= 1'b1;
      dirty_q[miss_idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: refill writes the whole line, a write hit writes one word.
  always_ff @(posedge clk) begin
    if (refill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= mem_rdata;
    end else if (wr_hit) begin
      data_q[req_idx][req_off] <= proc_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  // Tracks that the current request already missed, so its final hit is not counted.
  logic missed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
      missed_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (req && hit) begin
          if (!missed_q) hit_cnt <= hit_cnt + 32'd1;
          missed_q <= 1'b0;
        end else if (req) begin
          miss_cnt <= miss_cnt + 32'd1;
          missed_q <= 1'b1;
        end else begin
          missed_q <= 1'b0;
        end
      end
      if ((state_q == WBACK) && mem_ready) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed bench for dcache_direct_wb: cold miss, write/read hits, dirty eviction,
// slow memory with stable request, reset mid-refill, optional counters.
module tb_dcache_direct_wb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  localparam logic [127:0] LINE_A = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [127:0] LINE_B = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};
  localparam logic [127:0] LINE_C = {32'h33330003, 32'h33330002, 32'h33330001, 32'h33330000};
  localparam logic [127:0] LINE_D = {32'h77770003, 32'h77770002, 32'h77770001, 32'h77770000};

  dcache_direct_wb dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    settle();
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_stall", 128'(proc_stall), 128'(0));
    chk("rst_rdata", 128'(proc_rdata), 128'(0));

    // Stray mem_ready while idle has no effect.
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    settle();
    chk("idle_ready", 128'({proc_stall, mem_read, mem_write}), 128'(0));

    // 1: cold read miss on line 0x4.
    proc_read = 1'b1;
    proc_addr = 30'h10;
    settle();
    chk("s1_stall", 128'(proc_stall), 128'(1));
    cyc();
    settle();
    chk("s1_mem_req", 128'({mem_read, mem_write, mem_addr}), 128'({1'b1, 1'b0, 28'h4}));
    chk("s1_stall_alloc", 128'(proc_stall), 128'(1));
    mem_rdata = LINE_A;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    settle();
    chk("s1_stall_done", 128'(proc_stall), 128'(0));
    chk("s1_rdata", 128'(proc_rdata), 128'(32'hAAAA0000));
    chk("s1_mem_read_drop", 128'(mem_read), 128'(0));
    cyc();

    // 2: write hit then read hit, no memory traffic.
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 30'h11;
    proc_wdata = 32'h12345678;
    settle();
    chk("s2_wr_stall", 128'(proc_stall), 128'(0));
    cyc();
    proc_write = 1'b0;
    proc_read  = 1'b1;
    settle();
    chk("s2_rd", 128'(proc_rdata), 128'(32'h12345678));
    chk("s2_rd_stall", 128'(proc_stall), 128'(0));
    chk("s2_no_mem", 128'({mem_read, mem_write}), 128'(0));
    cyc();

    // 3: conflicting tag on the dirty line forces a write-back then refill.
    proc_addr = 30'h31;
    settle();
    chk("s3_stall", 128'(proc_stall), 128'(1));
    cyc();
    settle();
    chk("s3_wb_req", 128'({mem_write, mem_read, mem_addr}), 128'({1'b1, 1'b0, 28'h4}));
    chk("s3_wb_data", mem_wdata, {32'hDDDD0003, 32'hCCCC0002, 32'h12345678, 32'hAAAA0000});
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    settle();
    chk("s3_alloc_req", 128'({mem_write, mem_read, mem_addr}), 128'({1'b0, 1'b1, 28'hC}));
    mem_rdata = LINE_B;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    settle();
    chk("s3_stall_done", 128'(proc_stall), 128'(0));
    chk("s3_rdata", 128'(proc_rdata), 128'(32'h55550001));
    cyc();
    proc_read = 1'b0;
    settle();
`ifdef DCACHE_STATS_EN
    chk("s6_hit_cnt", 128'(hit_cnt), 128'(2));
    chk("s6_miss_cnt", 128'(miss_cnt), 128'(2));
    chk("s6_wb_cnt", 128'(wb_cnt), 128'(1));
`endif

    // 4a: clean write miss with a 10-cycle memory; request must hold steady.
    proc_write = 1'b1;
    proc_addr  = 30'h41;
    proc_wdata = 32'hCAFEF00D;
    settle();
    chk("s4_wr_stall", 128'(proc_stall), 128'(1));
    cyc();
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("s4_alloc_hold", 128'({mem_read, mem_write, mem_addr, proc_stall}),
          128'({1'b1, 1'b0, 28'h10, 1'b1}));
      if (i == 9) begin
        mem_rdata = LINE_C;
        mem_ready = 1'b1;
      end
      cyc();
    end
    mem_ready = 1'b0;
    settle();
    chk("s4_wr_hit", 128'({proc_stall, mem_read}), 128'(0));
    cyc();
    proc_write = 1'b0;
    settle();
    chk("s4_no_reissue0", 128'({mem_read, mem_write}), 128'(0));
    cyc();
    settle();
    chk("s4_no_reissue1", 128'({mem_read, mem_write}), 128'(0));

    // 4b: dirty eviction with a 10-cycle write-back; addr/wdata must hold steady.
    proc_read = 1'b1;
    proc_addr = 30'h60;
    cyc();
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("s4_wb_hold", 128'({mem_write, mem_read, mem_addr}), 128'({1'b1, 1'b0, 28'h10}));
      chk("s4_wb_data", mem_wdata, {32'h33330003, 32'h33330002, 32'hCAFEF00D, 32'h33330000});
      if (i == 9) mem_ready = 1'b1;
      cyc();
    end
    mem_ready = 1'b0;
    settle();
    chk("s4_alloc2", 128'({mem_write, mem_read, mem_addr}), 128'({1'b0, 1'b1, 28'h18}));
    mem_rdata = LINE_D;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    settle();
    chk("s4_rdata", 128'({proc_stall, proc_rdata}), 128'({1'b0, 32'h77770000}));
    cyc();
    proc_read = 1'b0;

    // 5: reset during a refill aborts it and invalidates every line.
    proc_read = 1'b1;
    proc_addr = 30'h10;
    cyc();
    settle();
    chk("s5_alloc", 128'(mem_read), 128'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    chk("s5_rst_mem_read", 128'({mem_read, mem_write}), 128'(0));
    chk("s5_rst_stall", 128'(proc_stall), 128'(1));
    proc_read = 1'b0;
    settle();
    chk("s5_idle", 128'(proc_stall), 128'(0));
    proc_read = 1'b1;
    proc_addr = 30'h31;
    settle();
    chk("s5_old_hit_misses", 128'(proc_stall), 128'(1));
    cyc();
    settle();
    chk("s5_refetch", 128'({mem_read, mem_write, mem_addr}), 128'({1'b1, 1'b0, 28'hC}));
    mem_rdata = LINE_B;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    settle();
    chk("s5_rdata", 128'({proc_stall, proc_rdata}), 128'({1'b0, 32'h55550001}));
    cyc();
    proc_read = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
